// File: rtl/encoder_pkg.sv
// Shared sizing, state encoding and bit-vector helpers for the serial 16-to-4 encoder.
package encoder_pkg;
    localparam int N = 16;
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Clears the lowest set bit.
    function automatic logic [N-1:0] drop_lowest(input logic [N-1:0] v);
        return v & (v - {{(N-1){1'b0}}, 1'b1});
    endfunction

    // True for zero or exactly one set bit.
    function automatic logic at_most_one(input logic [N-1:0] v);
        return drop_lowest(v) == '0;
    endfunction
endpackage

// File: rtl/prio_enc_16to4.sv
// Combinational priority encoder: index of the lowest set bit, plus an any-set flag.
module prio_enc_16to4
    import encoder_pkg::*;
(
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = |vec;
        // Descending scan so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end
endmodule

// File: rtl/encoder_16to4_serial.sv
// Serialises a request word into one beat per set bit (ascending index) over valid/ready.
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// EMIT  | presenting beats from pending until the last one transfers
module encoder_16to4_serial
    import encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic         out_last,
    output logic         out_zero
);
    state_t         state, state_nxt;
    logic [N-1:0]   pending, pending_nxt;
    logic           out_valid_nxt, out_last_nxt, out_zero_nxt;
    logic [W-1:0]   out_code_nxt;
    logic [W-1:0]   enc_idx;
    logic           enc_any;

    assign in_ready = (state == IDLE);

    // Encoding the next pending value lets every output be registered
    // while still presenting a fresh code on the cycle after each transfer.
    prio_enc_16to4 u_prio_enc (
        .vec (pending_nxt),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out_valid <= out_valid_nxt;
            out_code  <= out_code_nxt;
            out_last  <= out_last_nxt;
            out_zero  <= out_zero_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt   = EMIT;
                    pending_nxt = in_vec;
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    pending_nxt = drop_lowest(pending);
                    if (out_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        out_valid_nxt = (state_nxt == EMIT);
        out_code_nxt  = out_valid_nxt ? enc_idx : '0;
        out_last_nxt  = out_valid_nxt && at_most_one(pending_nxt);
        // Staying in EMIT with nothing pending only happens for an all-zero vector.
        out_zero_nxt  = out_valid_nxt && !enc_any;
    end
endmodule

// File: tb/tb_encoder_16to4_serial.sv
// Directed scoreboard bench for encoder_16to4_serial: expected beats queued at issue, checked by a monitor.
module tb_encoder_16to4_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_code;
    logic        out_last;
    logic        out_zero;

    int errors = 0;
    int checks = 0;
    int n_pop  = 0;
    bit toggle_ready = 1'b0;

    typedef struct packed {
        logic [3:0] code;
        logic       last;
        logic       zero;
    } beat_t;
    beat_t exp_q[$];

    encoder_16to4_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached (errors=%0d)", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int code, input bit last, input bit zero);
        beat_t b;
        b.code = 4'(code);
        b.last = last;
        b.zero = zero;
        return b;
    endfunction

    // out_ready driver: steady high, or alternating when toggle_ready is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_ready ? ~out_ready : 1'b1;
        end
    end

    // Monitor: pops on every transfer, and checks stability across stalls.
    initial begin
        beat_t exp_b;
        beat_t act_b;
        beat_t held;
        bit    stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                act_b = '{code: out_code, last: out_last, zero: out_zero};
                if (stalled) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_beat", 32'(act_b), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(act_b), 32'hFFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("beat", 32'(act_b), 32'(exp_b));
                    end
                    n_pop++;
                end
                stalled = out_valid && !out_ready;
                held    = act_b;
            end
        end
    end

    // Presents v and returns at #1 after the edge that accepted it.
    task automatic send(input logic [15:0] v);
        int n = 0;
        in_vec   = v;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("send_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int start;
        int n;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outs", {28'd0, out_valid, out_last, out_zero, |out_code}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single bit 0
        exp_q.push_back(mk(0, 1, 0));
        send(16'h0001);
        chk("t1_valid_after_accept", 32'(out_valid), 32'd1);
        chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_in_ready_back", 32'(in_ready), 32'd1);
        chk("t1_valid_clear", 32'(out_valid), 32'd0);
        drain();

        // 2: bits 0 and 15, consecutive beats
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(15, 1, 0));
        send(16'h8001);
        @(posedge clk);
        #1;
        chk("t2_second_beat", {27'd0, out_valid, out_code}, {27'd0, 1'b1, 4'd15});
        drain();

        // 3: all-zero vector
        exp_q.push_back(mk(0, 1, 1));
        send(16'h0000);
        drain();

        // 4: all ones with out_ready toggling
        for (int i = 0; i < 16; i++) exp_q.push_back(mk(i, i == 15, 0));
        toggle_ready = 1'b1;
        send(16'hFFFF);
        drain();
        toggle_ready = 1'b0;
        @(posedge clk);
        #1;

        // 5: in_valid held with a new vector during EMIT is ignored until IDLE
        for (int i = 4; i < 8; i++) exp_q.push_back(mk(i, i == 7, 0));
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(1, 1, 0));
        in_vec   = 16'h00F0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_vec = 16'h0003;
        send(16'h0003);
        drain();

        // 6: reset mid-stream after code 1, then a fresh vector
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 0, 0));
        for (int i = 8; i < 12; i++) exp_q.push_back(mk(i, i == 11, 0));
        start = n_pop;
        send(16'h0F0F);
        n = 0;
        while (n_pop < start + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_two_beats", 32'(n_pop - start), 32'd2);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_outs", {28'd0, out_valid, out_last, out_zero, |out_code}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(2, 1, 0));
        send(16'h0004);
        chk("t6_post_code", {27'd0, out_valid, out_code}, {27'd0, 1'b1, 4'd2});
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
